// File: rtl/duty_ctrl_pkg.sv
// Shared types and defaults for the duty-step button controller.
package duty_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } btn_state_e;

    localparam logic [3:0] DUTY_MIN_DEF  = 4'd1;
    localparam logic [3:0] DUTY_MAX_DEF  = 4'd9;
    localparam logic [3:0] DUTY_INIT_DEF = 4'd5;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One button: synchronizer, tick-sampled debounce history, press/hold FSM
// and auto-repeat counter. Emits a one-cycle request on press or repeat.
//
//   state | meaning
//   IDLE  | debounced level low, waiting for a press
//   HELD  | debounced level high, counting ticks toward the next repeat
module button_debounce
    import duty_ctrl_pkg::*;
#(
    parameter int DEB_SAMPLES  = 3,
    parameter int REPEAT_TICKS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn,
    output logic req
);

    localparam int RW = cnt_width(REPEAT_TICKS);
    localparam int RPT_LAST_I = (REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0;
    localparam logic [RW-1:0] RPT_LAST = RW'(RPT_LAST_I);

    logic                   sync_a;
    logic                   sync_b;
    logic [DEB_SAMPLES-1:0] hist;
    logic [DEB_SAMPLES-1:0] hist_next;
    logic                   level;
    logic                   level_next;
    btn_state_e             state;
    logic [RW-1:0]          rpt_cnt;
    logic                   press_evt;
    logic                   rpt_evt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
        end
    end

    assign hist_next = {hist[DEB_SAMPLES-2:0], sync_b};

    always_comb begin
        level_next = level;
        if (&hist_next)
            level_next = 1'b1;
        else if (~|hist_next)
            level_next = 1'b0;
    end

    assign press_evt = tick && (state == IDLE) && level_next;
    // Repeats only while every recent sample still reads pressed, so a
    // release still working through the debounce window adds no extra step.
    assign rpt_evt   = (REPEAT_TICKS > 0) && tick && (state == HELD)
                       && (&hist_next) && (rpt_cnt == RPT_LAST);
    assign req       = press_evt || rpt_evt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist    <= '0;
            level   <= 1'b0;
            state   <= IDLE;
            rpt_cnt <= '0;
        end else if (tick) begin
            hist  <= hist_next;
            level <= level_next;
            case (state)
                IDLE: begin
                    if (level_next) begin
                        state   <= HELD;
                        rpt_cnt <= '0;
                    end
                end
                HELD: begin
                    if (!level_next)
                        state <= IDLE;
                    else if (rpt_cnt == RPT_LAST)
                        rpt_cnt <= '0;
                    else
                        rpt_cnt <= rpt_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/duty_button_ctrl.sv
// Two debounced buttons stepping a saturating duty value for the PWM block.
// Owns the shared sample tick, inc/dec arbitration and the duty register.
module duty_button_ctrl
    import duty_ctrl_pkg::*;
#(
    parameter int         TICK_DIV     = 2,
    parameter int         DEB_SAMPLES  = 3,
    parameter int         REPEAT_TICKS = 4,
    parameter logic [3:0] DUTY_MIN     = DUTY_MIN_DEF,
    parameter logic [3:0] DUTY_MAX     = DUTY_MAX_DEF,
    parameter logic [3:0] DUTY_INIT    = DUTY_INIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic [3:0] duty,
    output logic       at_max,
    output logic       at_min
);

    localparam int TW = cnt_width(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          inc_req;
    logic          dec_req;
    logic          inc_go;
    logic          dec_go;

    assign tick = ena && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n)
            tick_cnt <= '0;
        else if (ena)
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end

    button_debounce #(
        .DEB_SAMPLES (DEB_SAMPLES),
        .REPEAT_TICKS(REPEAT_TICKS)
    ) u_inc (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick),
        .btn  (btn_inc),
        .req  (inc_req)
    );

    button_debounce #(
        .DEB_SAMPLES (DEB_SAMPLES),
        .REPEAT_TICKS(REPEAT_TICKS)
    ) u_dec (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick),
        .btn  (btn_dec),
        .req  (dec_req)
    );

    // Simultaneous requests cancel: neither direction wins.
    assign inc_go = ena && inc_req && !dec_req;
    assign dec_go = ena && dec_req && !inc_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
            duty      <= DUTY_INIT;
        end else begin
            inc_pulse <= inc_go;
            dec_pulse <= dec_go;
            if (inc_go && (duty < DUTY_MAX))
                duty <= duty + 4'd1;
            else if (dec_go && (duty > DUTY_MIN))
                duty <= duty - 4'd1;
        end
    end

    assign at_max = (duty == DUTY_MAX);
    assign at_min = (duty == DUTY_MIN);

endmodule

// File: tb/tb_duty_button_ctrl.sv
// Scoreboard bench for duty_button_ctrl: stimulus queues expected pulses,
// a negedge monitor pops and compares every pulse the DUT raises.
module tb_duty_button_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic       inc_pulse;
    logic       dec_pulse;
    logic [3:0] duty;
    logic       at_max;
    logic       at_min;

    typedef struct {
        logic       inc;
        logic       dec;
        logic [3:0] duty;
        int         deadline;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   r = 0;
    int   start = 0;

    always #5 clk = ~clk;

    duty_button_ctrl #(
        .TICK_DIV    (2),
        .DEB_SAMPLES (3),
        .REPEAT_TICKS(4),
        .DUTY_MIN    (4'd1),
        .DUTY_MAX    (4'd9),
        .DUTY_INIT   (4'd5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .btn_inc  (btn_inc),
        .btn_dec  (btn_dec),
        .inc_pulse(inc_pulse),
        .dec_pulse(dec_pulse),
        .duty     (duty),
        .at_max   (at_max),
        .at_min   (at_min)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            #1;
        end
    endtask

    // Three reset edges; on return r is the last edge sampled with rst_n low.
    task automatic do_reset();
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        r = cyc;
    endtask

    task automatic push(input logic inc, input logic dec, input logic [3:0] d, input int dl);
        exp_t e;
        e.inc = inc;
        e.dec = dec;
        e.duty = d;
        e.deadline = dl;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected pulses never seen, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (inc_pulse || dec_pulse) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse cycle %0d: got inc=%0b dec=%0b duty=%0d, required no pulse",
                             cyc, inc_pulse, dec_pulse, duty);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (inc_pulse !== mon_e.inc || dec_pulse !== mon_e.dec ||
                        duty !== mon_e.duty || cyc > mon_e.deadline) begin
                        errors++;
                        $display("FAIL pulse_check cycle %0d: got inc=%0b dec=%0b duty=%0d, required inc=%0b dec=%0b duty=%0d by cycle %0d",
                                 cyc, inc_pulse, dec_pulse, duty, mon_e.inc, mon_e.dec, mon_e.duty, mon_e.deadline);
                    end
                end
            end
        end
    end

    initial begin
        // Idle after reset.
        do_reset();
        check("reset_duty", int'(duty), 5);
        check("reset_inc_pulse", int'(inc_pulse), 0);
        check("reset_dec_pulse", int'(dec_pulse), 0);
        step(20);
        check("idle_duty", int'(duty), 5);
        check("idle_at_max", int'(at_max), 0);
        check("idle_at_min", int'(at_min), 0);
        check_drained("idle_pulses");

        // Clean press of 12 clk: press pulse lands 8 clk after the press.
        do_reset();
        step(4);
        start = cyc;
        btn_inc = 1'b1;
        push(1'b1, 1'b0, 4'd6, start + 10);
        step(12);
        btn_inc = 1'b0;
        step(20);
        check("single_press_duty", int'(duty), 6);
        check_drained("single_press_pulses");

        // Chatter: every sample tick lands on a low half of the bounce.
        do_reset();
        step(4);
        for (int i = 0; i < 10; i++) begin
            btn_inc = (((cyc - r) % 2) == 0);
            step(1);
        end
        btn_inc = 1'b0;
        step(20);
        check("bounce_duty", int'(duty), 5);
        check_drained("bounce_pulses");

        // Long inc hold: press then repeats every 8 clk, saturating at 9.
        do_reset();
        step(4);
        start = cyc;
        btn_inc = 1'b1;
        push(1'b1, 1'b0, 4'd6, start + 10);
        push(1'b1, 1'b0, 4'd7, start + 18);
        push(1'b1, 1'b0, 4'd8, start + 26);
        push(1'b1, 1'b0, 4'd9, start + 34);
        push(1'b1, 1'b0, 4'd9, start + 42);
        push(1'b1, 1'b0, 4'd9, start + 50);
        push(1'b1, 1'b0, 4'd9, start + 58);
        step(60);
        btn_inc = 1'b0;
        step(20);
        check("repeat_inc_duty", int'(duty), 9);
        check("repeat_inc_at_max", int'(at_max), 1);
        check("repeat_inc_at_min", int'(at_min), 0);
        check_drained("repeat_inc_pulses");

        // Long dec hold: saturates at 1.
        do_reset();
        step(4);
        start = cyc;
        btn_dec = 1'b1;
        push(1'b0, 1'b1, 4'd4, start + 10);
        push(1'b0, 1'b1, 4'd3, start + 18);
        push(1'b0, 1'b1, 4'd2, start + 26);
        push(1'b0, 1'b1, 4'd1, start + 34);
        push(1'b0, 1'b1, 4'd1, start + 42);
        push(1'b0, 1'b1, 4'd1, start + 50);
        push(1'b0, 1'b1, 4'd1, start + 58);
        step(60);
        btn_dec = 1'b0;
        step(20);
        check("repeat_dec_duty", int'(duty), 1);
        check("repeat_dec_at_min", int'(at_min), 1);
        check("repeat_dec_at_max", int'(at_max), 0);
        check_drained("repeat_dec_pulses");

        // Both buttons together cancel.
        do_reset();
        step(4);
        btn_inc = 1'b1;
        btn_dec = 1'b1;
        step(12);
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        step(20);
        check("both_duty", int'(duty), 5);
        check_drained("both_pulses");

        // Disabled hold, then reset mid-hold re-arms a single press.
        do_reset();
        step(2);
        ena = 1'b0;
        btn_dec = 1'b1;
        step(30);
        check("disabled_duty", int'(duty), 5);
        check_drained("disabled_pulses");
        ena = 1'b1;
        do_reset();
        check("rearm_reset_duty", int'(duty), 5);
        start = cyc;
        push(1'b0, 1'b1, 4'd4, start + 10);
        step(12);
        btn_dec = 1'b0;
        step(20);
        check("rearm_duty", int'(duty), 4);
        check_drained("rearm_pulses");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/duty_button_ctrl.md
DUTY_BUTTON_CTRL -- requirements
Module: duty_button_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, 2, clk cycles per debounce sample tick (set to 25000000 for 4 Hz board operation), minimum 1.
REQ-002 SHALL have parameter DEB_SAMPLES, 3, consecutive equal tick samples required to change the debounced level, range 2..8.
REQ-003 SHALL have parameter REPEAT_TICKS, 4, ticks between auto-repeat pulses while held; 0 disables auto-repeat.
REQ-004 SHALL have parameters DUTY_MIN 1, DUTY_MAX 9 and DUTY_INIT 5, the duty-step limits and reset value (4-bit).
REQ-005 SHALL have port clk input 1, the single rising-edge clock.
REQ-006 SHALL have port rst_n input 1; reset rst_n, synchronous, active-low; clock clk.
REQ-007 SHALL have port ena input 1, functional enable.
REQ-008 SHALL have port btn_inc input 1, raw asynchronous increase button, active high.
REQ-009 SHALL have port btn_dec input 1, raw asynchronous decrease button, active high.
REQ-010 SHALL have port inc_pulse output 1, one-clk increase request, registered.
REQ-011 SHALL have port dec_pulse output 1, one-clk decrease request, registered.
REQ-012 SHALL have port duty output 4, current duty step, consumed directly by the PWM generator.
REQ-013 SHALL have ports at_max and at_min, output 1 each, combinational compares: duty==DUTY_MAX and duty==DUTY_MIN.

Function
REQ-014 SHALL pass each raw button through a 2-FF synchronizer clocked every clk, regardless of ena.
REQ-015 SHALL run a tick counter 0..TICK_DIV-1 that increments only when ena=1; tick is high for one clk when the counter equals TICK_DIV-1, and the counter wraps to 0 on that edge.
REQ-016 SHALL, on each tick, shift the synchronized level into a DEB_SAMPLES-bit history; the debounced level becomes 1 when all history bits are 1, becomes 0 when all are 0, and otherwise holds.
REQ-017 SHALL implement a per-button FSM: IDLE -> HELD on a debounced 0->1 edge (emitting a press request); HELD -> IDLE on a debounced 1->0 edge (no request).
REQ-018 SHALL, in HELD with REPEAT_TICKS>0, count ticks from 0 and emit a repeat request and clear the count when the count reaches REPEAT_TICKS-1 on a tick; the count is cleared on entry to HELD.
REQ-019 SHALL register each request to its pulse output, high for exactly one clk, in the cycle after the debounced edge or repeat tick.
REQ-020 SHALL suppress both pulses, leaving duty unchanged, when inc and dec requests occur in the same cycle.
REQ-021 SHALL update duty on the same edge that raises a pulse: +1 on inc_pulse if duty<DUTY_MAX, -1 on dec_pulse if duty>DUTY_MIN, otherwise hold (saturate, never wrap).
REQ-022 SHALL still emit the pulse when saturated; only duty is held.
REQ-023 SHALL, when ena=0, freeze the tick counter, histories, FSMs and duty and drive both pulses 0.

Reset
REQ-024 SHALL, while rst_n=0 at a clk edge, set: inc_pulse=0, dec_pulse=0, duty=DUTY_INIT, tick counter=0, histories=0, debounced levels=0, FSMs=IDLE, repeat counts=0, synchronizers=0.
REQ-025 SHALL treat a button still held on reset release as a new press: exactly one press pulse after DEB_SAMPLES ticks.

Structure
REQ-026 SHALL place the FSM state enum (IDLE, HELD) and the DUTY_MIN/DUTY_MAX/DUTY_INIT defaults in shared package duty_ctrl_pkg.
REQ-027 SHALL use one sub-module, button_debounce (synchronizer, history, FSM, repeat counter, request output), instantiated twice; the tick counter, arbitration and duty register live in the top.

Verification (TICK_DIV=2, DEB_SAMPLES=3, REPEAT_TICKS=4)
REQ-028 Reset held 3 clk, then idle for 20 clk -> duty=5, pulses never high, at_max=0, at_min=0.
REQ-029 btn_inc held clean for 12 clk, then released -> exactly one inc_pulse, at most 10 clk after press; duty=6.
REQ-030 btn_inc toggled every clk for 10 clk, then low for 20 clk -> no pulse; duty=5.
REQ-031 btn_inc held for 60 clk -> press pulse, then a repeat pulse every 8 clk; duty climbs to 9, at_max=1; later pulses leave duty at 9.
REQ-032 Both buttons rising on the same clk and held for 12 clk -> no pulses; duty=5.
REQ-033 ena=0 with btn_dec held for 30 clk -> no pulse. Then ena=1 with rst_n pulsed low mid-hold -> duty=5, then exactly one dec_pulse giving duty=4.
